// File: rtl/count_checker.sv
// count_checker: monitors a sampled free-running count bus for +1 steps,
// tracking lock, wrap, restart-to-zero and sequence errors with a saturating tally.
module count_checker #(
  parameter int WIDTH    = 8,
  parameter int LOCK_LEN = 4,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] count_in,
  input  logic             count_valid,
  input  logic             clear,
  output logic             locked,
  output logic             err_pulse,
  output logic             restart_pulse,
  output logic             wrap_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [WIDTH-1:0] expected
);
  localparam int RW = $clog2(LOCK_LEN + 1);
  localparam logic [RW-1:0] LOCK_RUN = RW'(LOCK_LEN);
  typedef enum logic [1:0] {IDLE, SYNC, LOCKED} state_t;
  state_t state_q, state_d;
  logic [RW-1:0] run_q, run_d, run_inc;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic err_q, err_d, restart_q, restart_d, wrap_q, wrap_d;
  logic correct, is_zero;
  assign correct = count_in == exp_q;
  assign is_zero = count_in == '0;
  assign run_inc = run_q + 1'b1;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      run_q     <= '0;
      exp_q     <= '0;
      err_cnt_q <= '0;
      err_q     <= 1'b0;
      restart_q <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      run_q     <= run_d;
      exp_q     <= exp_d;
      err_cnt_q <= err_cnt_d;
      err_q     <= err_d;
      restart_q <= restart_d;
      wrap_q    <= wrap_d;
    end
  end
  // every valid sample resynchronises expected, correct or not
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    exp_d   = exp_q;
    if (clear) begin
      state_d = IDLE;
      run_d   = '0;
      exp_d   = '0;
    end else if (count_valid) begin
      exp_d   = count_in + 1'b1;
      run_d   = (state_q == SYNC && correct && run_inc != LOCK_RUN) ? run_inc : '0;
      state_d = state_q == IDLE ? SYNC :
                state_q == SYNC ? ((correct && run_inc == LOCK_RUN) ? LOCKED : SYNC) :
                correct ? LOCKED : SYNC;
    end
  end
  always_comb begin
    err_d     = 1'b0;
    restart_d = 1'b0;
    wrap_d    = 1'b0;
    err_cnt_d = err_cnt_q;
    if (clear) begin
      err_cnt_d = '0;
    end else if (count_valid) begin
      wrap_d    = state_q != IDLE && correct && is_zero;
      restart_d = state_q == LOCKED && !correct && is_zero;
      err_d     = state_q == LOCKED && !correct && !is_zero;
      err_cnt_d = (err_d && err_cnt_q != '1) ? err_cnt_q + 1'b1 : err_cnt_q;
    end
  end
  assign locked        = state_q == LOCKED;
  assign err_pulse     = err_q;
  assign restart_pulse = restart_q;
  assign wrap_pulse    = wrap_q;
  assign err_count     = err_cnt_q;
  assign expected      = exp_q;
endmodule

// File: tb/tb_count_checker.sv
// tb_count_checker: directed vectors for count_checker (default and ERR_W=2 instances).
module tb_count_checker;
  logic clk = 0, reset = 1, count_valid = 0, clear = 0;
  logic [7:0] count_in = '0;
  logic lk0, ep0, rp0, wp0, lk1, ep1, rp1, wp1;
  logic [7:0] ec0, ex0, ex1;
  logic [1:0] ec1;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  count_checker dut0 (
    .clk(clk), .reset(reset), .count_in(count_in), .count_valid(count_valid), .clear(clear),
    .locked(lk0), .err_pulse(ep0), .restart_pulse(rp0), .wrap_pulse(wp0),
    .err_count(ec0), .expected(ex0)
  );
  count_checker #(.ERR_W(2)) dut1 (
    .clk(clk), .reset(reset), .count_in(count_in), .count_valid(count_valid), .clear(clear),
    .locked(lk1), .err_pulse(ep1), .restart_pulse(rp1), .wrap_pulse(wp1),
    .err_count(ec1), .expected(ex1)
  );
  typedef struct {
    logic v, c;
    logic [7:0] cnt;
    logic lk, ep, rp, wp;
    logic [7:0] ec, ex;
  } vec_t;
  vec_t tbl[$];
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask
  task automatic step(input logic v, input logic c, input logic [7:0] cnt);
    count_valid = v;
    clear = c;
    count_in = cnt;
    @(posedge clk);
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    tbl.push_back('{1,0,0,   0,0,0,0,0,1});
    tbl.push_back('{1,0,1,   0,0,0,0,0,2});
    tbl.push_back('{1,0,2,   0,0,0,0,0,3});
    tbl.push_back('{1,0,3,   0,0,0,0,0,4});
    tbl.push_back('{1,0,4,   1,0,0,0,0,5});
    tbl.push_back('{1,0,5,   1,0,0,0,0,6});
    tbl.push_back('{1,1,99,  0,0,0,0,0,0});
    tbl.push_back('{1,0,250, 0,0,0,0,0,251});
    tbl.push_back('{1,0,251, 0,0,0,0,0,252});
    tbl.push_back('{1,0,252, 0,0,0,0,0,253});
    tbl.push_back('{1,0,253, 0,0,0,0,0,254});
    tbl.push_back('{1,0,254, 1,0,0,0,0,255});
    tbl.push_back('{1,0,255, 1,0,0,0,0,0});
    tbl.push_back('{1,0,0,   1,0,0,1,0,1});
    tbl.push_back('{1,0,1,   1,0,0,0,0,2});
    tbl.push_back('{0,0,77,  1,0,0,0,0,2});
    tbl.push_back('{1,0,2,   1,0,0,0,0,3});
    tbl.push_back('{1,0,3,   1,0,0,0,0,4});
    tbl.push_back('{1,0,4,   1,0,0,0,0,5});
    tbl.push_back('{1,0,5,   1,0,0,0,0,6});
    tbl.push_back('{1,0,6,   1,0,0,0,0,7});
    tbl.push_back('{1,0,8,   0,1,0,0,1,9});
    tbl.push_back('{1,0,9,   0,0,0,0,1,10});
    tbl.push_back('{1,0,10,  0,0,0,0,1,11});
    tbl.push_back('{1,0,11,  0,0,0,0,1,12});
    tbl.push_back('{1,0,12,  1,0,0,0,1,13});
    tbl.push_back('{1,0,13,  1,0,0,0,1,14});
    tbl.push_back('{1,0,0,   0,0,1,0,1,1});
    tbl.push_back('{1,0,1,   0,0,0,0,1,2});
    tbl.push_back('{1,0,2,   0,0,0,0,1,3});
    tbl.push_back('{1,0,3,   0,0,0,0,1,4});
    tbl.push_back('{1,0,4,   1,0,0,0,1,5});
    tbl.push_back('{1,1,0,   0,0,0,0,0,0});
    tbl.push_back('{1,0,255, 0,0,0,0,0,0});
    tbl.push_back('{1,0,0,   0,0,0,1,0,1});
    tbl.push_back('{1,0,40,  0,0,0,0,0,41});
    tbl.push_back('{1,1,55,  0,0,0,0,0,0});
    tbl.push_back('{1,0,0,   0,0,0,0,0,1});
    tbl.push_back('{0,0,200, 0,0,0,0,0,1});
    tbl.push_back('{1,0,1,   0,0,0,0,0,2});
    tbl.push_back('{0,0,200, 0,0,0,0,0,2});
    tbl.push_back('{1,0,2,   0,0,0,0,0,3});
    tbl.push_back('{0,0,200, 0,0,0,0,0,3});
    tbl.push_back('{1,0,3,   0,0,0,0,0,4});
    tbl.push_back('{0,0,200, 0,0,0,0,0,4});
    tbl.push_back('{1,0,4,   1,0,0,0,0,5});
    repeat (2) @(posedge clk);
    #1 reset = 0;
    chk("reset_state", {lk0, ep0, rp0, wp0, ec0, ex0}, 20'h0);
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].v, tbl[i].c, tbl[i].cnt);
      chk($sformatf("vec%0d", i), {lk0, ep0, rp0, wp0, ec0, ex0},
          {tbl[i].lk, tbl[i].ep, tbl[i].rp, tbl[i].wp, tbl[i].ec, tbl[i].ex});
    end
    // saturating tally on the 2-bit instance: five lock-then-skip episodes
    step(1, 1, 0);
    for (int e = 0; e < 5; e++) begin
      for (int k = 0; k < 5; k++) step(1, 0, 8'(k));
      chk($sformatf("ep%0d_locked", e), {31'd0, lk1}, 32'd1);
      step(1, 0, 6);
      chk($sformatf("ep%0d_errc", e), {30'd0, ec1}, e < 3 ? 32'(e + 1) : 32'd3);
      chk($sformatf("ep%0d_pulse", e), {29'd0, ep1, rp1, wp1}, 32'b100);
    end
    chk("wide_errc", {24'd0, ec0}, 32'd5);
    step(1, 1, 9);
    chk("clr_errc", {30'd0, ec1}, 32'd0);
    chk("clr_state", {lk1, ep1, rp1, wp1, ex1}, 12'h0);
    step(1, 0, 5);
    chk("after_clr", {lk1, ep1, rp1, wp1, ex1}, {4'b0, 8'd6});
    for (int k = 6; k < 10; k++) step(1, 0, 8'(k));
    chk("relock", {31'd0, lk1}, 32'd1);
    step(1, 0, 20);
    chk("err_pre_rst", {ec0, 6'd0, ec1}, {8'd1, 8'd1});
    for (int k = 21; k < 25; k++) step(1, 0, 8'(k));
    chk("locked_pre_rst", {30'd0, lk0, lk1}, 32'd3);
    count_valid = 0;
    #2 reset = 1;
    #1;
    chk("async_rst", {lk0, lk1, ec0, 6'd0, ec1, ex0}, 26'd0);
    #1 reset = 0;
    step(1, 0, 37);
    chk("post_rst_idle", {lk0, ep0, rp0, wp0, ec0, ex0}, {12'h0, 8'd38});
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
